// File: rtl/vna_acc_pkg.sv
// Shared definitions for the I/Q accumulator: default widths, output beat
// field offsets and the integration FSM state encoding.
package vna_acc_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 48;
  localparam int unsigned CNT_W_DEF  = 32;

  // Field offsets inside the output beat {count, q_sum, i_sum}
  localparam int unsigned I_LSB   = 0;
  localparam int unsigned Q_LSB   = ACC_W_DEF;
  localparam int unsigned CNT_LSB = 2 * ACC_W_DEF;

  localparam int unsigned TDATA_W_DEF = 2 * ACC_W_DEF + CNT_W_DEF;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/iq_accumulator_if.sv
// AXI-Stream style output link from the accumulator to the packetiser.
interface iq_accumulator_if
  import vna_acc_pkg::*;
#(
  parameter int unsigned TDATA_W = TDATA_W_DEF
) ();

  logic [TDATA_W-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);

endinterface

// File: rtl/acc_out_fifo.sv
// Two-entry valid/ready buffer; the head register drives the outputs
// directly so data stays stable while stalled.
module acc_out_fifo #(
  parameter int unsigned W = 129
) (
  input  logic         aclk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         pop_o,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  input  logic         ready_i
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         head_v_q;
  logic         tail_v_q;

  assign pop_o   = head_v_q & ready_i;
  assign full_o  = head_v_q & tail_v_q;
  assign dout_o  = head_q;
  assign valid_o = head_v_q;

  // Head/tail update; a push while full is only taken if a pop frees a slot
  always_ff @(posedge aclk) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      head_v_q <= 1'b0;
      tail_v_q <= 1'b0;
    end else if (pop_o) begin
      if (tail_v_q) begin
        head_q <= tail_q;
        if (push_i) begin
          tail_q <= din_i;
        end else begin
          tail_v_q <= 1'b0;
        end
      end else if (push_i) begin
        head_q <= din_i;
      end else begin
        head_v_q <= 1'b0;
      end
    end else if (push_i) begin
      if (!head_v_q) begin
        head_q   <= din_i;
        head_v_q <= 1'b1;
      end else if (!tail_v_q) begin
        tail_q   <= din_i;
        tail_v_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/iq_accumulator.sv
// Integrates signed I/Q samples across each acc_trigger window and emits one
// {count, q_sum, i_sum} beat per frequency point, tagging the sweep's last.
module iq_accumulator
  import vna_acc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_i,
  input  logic [DATA_W-1:0] s_q,
  input  logic              s_valid,
  input  logic              acc_trigger,
  input  logic [15:0]       points_per_sweep,
  iq_accumulator_if.master  m_axis,
  output logic              overrun,
  output logic [15:0]       drop_count
);

  localparam int unsigned TDATA_W = 2 * ACC_W + CNT_W;

  acc_state_e       state_q;
  logic             trig_q;
  logic [ACC_W-1:0] i_sum_q;
  logic [ACC_W-1:0] q_sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      pps_q;
  logic [15:0]      pt_idx_q;
  logic [15:0]      pt_idx_d;
  logic             overrun_q;
  logic             overrun_d;
  logic [15:0]      drop_q;
  logic [15:0]      drop_d;

  logic [ACC_W-1:0] i_ext;
  logic [ACC_W-1:0] q_ext;
  logic [CNT_W-1:0] cnt_inc;
  logic             win_end;
  logic             pt_last;
  logic             fifo_full;
  logic             fifo_pop;
  logic             drop;
  logic [TDATA_W:0] fifo_din;
  logic [TDATA_W:0] fifo_dout;

  assign i_ext   = ACC_W'($signed(s_i));
  assign q_ext   = ACC_W'($signed(s_q));
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // trig_q high means the previous cycle was inside the window
  assign win_end = trig_q & ~acc_trigger;
  assign pt_last = (pt_idx_q == pps_q - 16'd1);
  assign drop    = win_end & fifo_full & ~fifo_pop;
  assign fifo_din = {pt_last, cnt_q, q_sum_q, i_sum_q};

  // Integration FSM and accumulators
  always_ff @(posedge aclk) begin
    if (!rst) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      i_sum_q <= '0;
      q_sum_q <= '0;
      cnt_q   <= '0;
    end else begin
      trig_q <= acc_trigger;
      case (state_q)
        IDLE: begin
          if (acc_trigger) begin
            state_q <= ACCUM;
            if (s_valid) begin
              i_sum_q <= i_ext;
              q_sum_q <= q_ext;
              cnt_q   <= CNT_W'(1);
            end else begin
              i_sum_q <= '0;
              q_sum_q <= '0;
              cnt_q   <= '0;
            end
          end
        end
        ACCUM: begin
          if (!acc_trigger) begin
            state_q <= IDLE;
          end else if (s_valid) begin
            i_sum_q <= i_sum_q + i_ext;
            q_sum_q <= q_sum_q + q_ext;
            cnt_q   <= cnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Point index and drop bookkeeping; index advances on drops too
  always_comb begin
    pt_idx_d  = pt_idx_q;
    overrun_d = overrun_q;
    drop_d    = drop_q;
    if (win_end) begin
      pt_idx_d = pt_last ? 16'd0 : pt_idx_q + 16'd1;
    end
    if (drop) begin
      overrun_d = 1'b1;
      drop_d    = (&drop_q) ? drop_q : drop_q + 16'd1;
    end
  end

  // Point counters; points_per_sweep is captured only during reset
  always_ff @(posedge aclk) begin
    if (!rst) begin
      pps_q     <= (points_per_sweep == 16'd0) ? 16'd1 : points_per_sweep;
      pt_idx_q  <= '0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      pt_idx_q  <= pt_idx_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  acc_out_fifo #(
    .W(TDATA_W + 1)
  ) u_fifo (
    .aclk    (aclk),
    .rst     (rst),
    .push_i  (win_end),
    .din_i   (fifo_din),
    .full_o  (fifo_full),
    .pop_o   (fifo_pop),
    .dout_o  (fifo_dout),
    .valid_o (m_axis.tvalid),
    .ready_i (m_axis.tready)
  );

  assign m_axis.tlast = fifo_dout[TDATA_W];
  assign m_axis.tdata = fifo_dout[TDATA_W-1:0];
  assign overrun      = overrun_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_iq_accumulator.sv
// Directed bench for iq_accumulator with hand-computed expected beats.
module tb_iq_accumulator;
  import vna_acc_pkg::*;

  logic        aclk = 1'b0;
  logic        rst  = 1'b0;
  logic [15:0] s_i  = '0;
  logic [15:0] s_q  = '0;
  logic        s_valid = 1'b0;
  logic        acc_trigger = 1'b0;
  logic [15:0] points_per_sweep = 16'd3;
  logic        overrun;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  iq_accumulator_if m_axis_if ();

  iq_accumulator #(
    .DATA_W(DATA_W_DEF),
    .ACC_W (ACC_W_DEF),
    .CNT_W (CNT_W_DEF)
  ) dut (
    .aclk            (aclk),
    .rst             (rst),
    .s_i             (s_i),
    .s_q             (s_q),
    .s_valid         (s_valid),
    .acc_trigger     (acc_trigger),
    .points_per_sweep(points_per_sweep),
    .m_axis          (m_axis_if),
    .overrun         (overrun),
    .drop_count      (drop_count)
  );

  logic [ACC_W_DEF-1:0] f_i;
  logic [ACC_W_DEF-1:0] f_q;
  logic [CNT_W_DEF-1:0] f_cnt;
  assign f_i   = m_axis_if.tdata[I_LSB +: ACC_W_DEF];
  assign f_q   = m_axis_if.tdata[Q_LSB +: ACC_W_DEF];
  assign f_cnt = m_axis_if.tdata[CNT_LSB +: CNT_W_DEF];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the capturing edge
  task automatic cyc(input logic trig, input logic v, input logic [15:0] i, input logic [15:0] q);
    acc_trigger = trig;
    s_valid     = v;
    s_i         = i;
    s_q         = q;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    points_per_sweep = 16'd3;
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    rst = 1'b1;
  endtask

  task automatic window(input int unsigned len, input logic [15:0] i);
    for (int unsigned k = 0; k < len; k++) cyc(1'b1, 1'b1, i, 16'd0);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  initial begin
    m_axis_if.tready = 1'b1;
    do_reset();
    check("rst_tvalid", 128'(m_axis_if.tvalid), 128'd0);
    check("rst_tlast",  128'(m_axis_if.tlast),  128'd0);
    check("rst_tdata",  m_axis_if.tdata,        128'd0);
    check("rst_overrun", 128'(overrun),         128'd0);
    check("rst_drops",  128'(drop_count),       128'd0);

    // Basic 4-sample window
    cyc(1'b1, 1'b1, 16'd100, 16'd2);
    cyc(1'b1, 1'b1, -16'sd50, 16'd2);
    cyc(1'b1, 1'b1, 16'd7, 16'd2);
    cyc(1'b1, 1'b1, 16'd1, 16'd2);
    check("t1_no_early_valid", 128'(m_axis_if.tvalid), 128'd0);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    check("t1_tvalid", 128'(m_axis_if.tvalid), 128'd1);
    check("t1_i_sum",  128'(f_i),   128'd58);
    check("t1_q_sum",  128'(f_q),   128'd8);
    check("t1_count",  128'(f_cnt), 128'd4);
    check("t1_tlast",  128'(m_axis_if.tlast), 128'd0);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    check("t1_drained", 128'(m_axis_if.tvalid), 128'd0);

    // tlast pattern over a 3-point sweep plus wrap
    do_reset();
    for (int k = 0; k < 4; k++) begin
      window(1, 16'd5);
      check("t2_tvalid", 128'(m_axis_if.tvalid), 128'd1);
      check("t2_tlast",  128'(m_axis_if.tlast), (k == 2) ? 128'd1 : 128'd0);
      cyc(1'b0, 1'b0, 16'd0, 16'd0);
    end

    // Back-pressure: four windows, two stored, two dropped
    do_reset();
    m_axis_if.tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      window(2, 16'd1);
      check("t3_hold_valid", 128'(m_axis_if.tvalid), 128'd1);
      check("t3_hold_count", 128'(f_cnt), 128'd2);
      check("t3_hold_i",     128'(f_i),   128'd2);
      check("t3_hold_tlast", 128'(m_axis_if.tlast), 128'd0);
      if (k == 1) check("t3_no_drop_yet", 128'(drop_count), 128'd0);
    end
    check("t3_overrun", 128'(overrun),    128'd1);
    check("t3_drops",   128'(drop_count), 128'd2);
    m_axis_if.tready = 1'b1;
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    check("t3_second_beat", 128'(m_axis_if.tvalid), 128'd1);
    check("t3_second_cnt",  128'(f_cnt), 128'd2);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    check("t3_empty", 128'(m_axis_if.tvalid), 128'd0);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    check("t3_still_empty", 128'(m_axis_if.tvalid), 128'd0);
    check("t3_drops_kept",  128'(drop_count), 128'd2);

    // Full FIFO with simultaneous push and pop
    do_reset();
    m_axis_if.tready = 1'b0;
    window(1, 16'd10);
    window(1, 16'd20);
    cyc(1'b1, 1'b1, 16'd30, 16'd0);
    m_axis_if.tready = 1'b1;
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    check("t4_drops",   128'(drop_count), 128'd0);
    check("t4_overrun", 128'(overrun),    128'd0);
    check("t4_head_b",  128'(f_i),        128'd20);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    check("t4_valid_c", 128'(m_axis_if.tvalid), 128'd1);
    check("t4_head_c",  128'(f_i),              128'd30);
    check("t4_tlast_c", 128'(m_axis_if.tlast),  128'd1);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    check("t4_empty",   128'(m_axis_if.tvalid), 128'd0);

    // Sparse valid with most-negative samples, then an empty window
    do_reset();
    cyc(1'b1, 1'b1, 16'h8000, 16'd0);
    cyc(1'b1, 1'b0, 16'h8000, 16'd0);
    cyc(1'b1, 1'b1, 16'h8000, 16'd0);
    cyc(1'b1, 1'b0, 16'h8000, 16'd0);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    check("t5_valid", 128'(m_axis_if.tvalid), 128'd1);
    check("t5_i_neg", 128'(f_i),   128'h0000_0000_0000_0000_0000_FFFF_FFFF_0000);
    check("t5_count", 128'(f_cnt), 128'd2);
    cyc(1'b1, 1'b0, 16'd5, 16'd5);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);
    check("t5_zero_valid", 128'(m_axis_if.tvalid), 128'd1);
    check("t5_zero_data",  m_axis_if.tdata,        128'd0);
    cyc(1'b0, 1'b0, 16'd0, 16'd0);

    // Reset mid-window with a buffered beat
    do_reset();
    m_axis_if.tready = 1'b0;
    window(2, 16'd1);
    check("t6_buffered", 128'(m_axis_if.tvalid), 128'd1);
    cyc(1'b1, 1'b1, 16'd3, 16'd3);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 16'd3, 16'd3);
    check("t6_rst_valid", 128'(m_axis_if.tvalid), 128'd0);
    check("t6_rst_data",  m_axis_if.tdata,        128'd0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 16'd0, 16'd0);
      check("t6_no_ghost", 128'(m_axis_if.tvalid), 128'd0);
    end
    m_axis_if.tready = 1'b1;
    window(1, 16'd4);
    check("t6_new_valid", 128'(m_axis_if.tvalid), 128'd1);
    check("t6_new_i",     128'(f_i),   128'd4);
    check("t6_new_cnt",   128'(f_cnt), 128'd1);
    check("t6_new_tlast", 128'(m_axis_if.tlast), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
